// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared opcode/ALU encodings and the instruction decoder for the execute/control slice.
package cpu_exec_ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_RSUB = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_ANDN = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_NOR  = 3'b111
  } alu_op_e;

  // branch marks beq; it is qualified with the ALU zero flag to form PCSrc.
  typedef struct packed {
    logic    pc_wre;
    logic    alu_src_b;
    logic    alu_m2reg;
    logic    reg_wre;
    logic    data_mem_rw;
    logic    ext_sel;
    logic    branch;
    logic    reg_out;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c        = '0;
    c.pc_wre = 1'b1;
    c.alu_op = ALU_ADD;
    case (op)
      OP_ADD:  begin c.reg_wre = 1'b1; c.reg_out = 1'b1; end
      OP_ADDI: begin c.reg_wre = 1'b1; c.alu_src_b = 1'b1; c.ext_sel = 1'b1; end
      OP_SUB:  begin c.reg_wre = 1'b1; c.reg_out = 1'b1; c.alu_op = ALU_SUB; end
      OP_ORI:  begin c.reg_wre = 1'b1; c.alu_src_b = 1'b1; c.alu_op = ALU_OR; end
      OP_AND:  begin c.reg_wre = 1'b1; c.reg_out = 1'b1; c.alu_op = ALU_AND; end
      OP_OR:   begin c.reg_wre = 1'b1; c.reg_out = 1'b1; c.alu_op = ALU_OR; end
      OP_MOVE: begin c.reg_wre = 1'b1; c.reg_out = 1'b1; end
      OP_SW:   begin c.data_mem_rw = 1'b1; c.alu_src_b = 1'b1; c.ext_sel = 1'b1; end
      OP_LW: begin
        c.reg_wre   = 1'b1;
        c.alu_src_b = 1'b1;
        c.ext_sel   = 1'b1;
        c.alu_m2reg = 1'b1;
      end
      OP_BEQ:  begin c.ext_sel = 1'b1; c.branch = 1'b1; c.alu_op = ALU_SUB; end
      OP_HALT: c.pc_wre = 1'b0;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// Datapath/control bundle between the execute/control slice and the rest of the CPU.
interface cpu_exec_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
);
    logic [OP_W-1:0]  operation;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] PCOut;
    logic [WIDTH-1:0] shiftResult;

    logic [WIDTH-1:0] ALUresult;
    logic             zero;
    logic [WIDTH-1:0] Add_result1;
    logic [WIDTH-1:0] Add_result2;
    logic             PCWre;
    logic             ALUSrcB;
    logic             ALUM2Reg;
    logic             RegWre;
    logic             InsMemRW;
    logic             DataMemRW;
    logic             ExtSel;
    logic             PCSrc;
    logic             RegOut;
    logic [2:0]       ALUOp;

    // master: the surrounding datapath; slave: cpu_exec_ctrl.
    modport master (
        output operation, ReadData1, B, PCOut, shiftResult,
        input  ALUresult, zero, Add_result1, Add_result2,
        input  PCWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW,
        input  DataMemRW, ExtSel, PCSrc, RegOut, ALUOp
    );

    modport slave (
        input  operation, ReadData1, B, PCOut, shiftResult,
        output ALUresult, zero, Add_result1, Add_result2,
        output PCWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW,
        output DataMemRW, ExtSel, PCSrc, RegOut, ALUOp
    );
endinterface

// File: rtl/cpu_adder32.sv
// Plain wrap-around adder used for PC+4 and the branch target.
module cpu_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/cpu_alu.sv
// 32-bit ALU, modulo 2^WIDTH arithmetic, with a zero flag on the result.
module cpu_alu
    import cpu_exec_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_RSUB: result = b - a;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_ANDN: result = ~a & b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execute/control slice: opcode decode, ALU, PC adders and the sticky halt flag.
module cpu_exec_ctrl
    import cpu_exec_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
) (
    input  logic            CLK,
    input  logic            Reset,
    cpu_exec_ctrl_if.slave  bus
);

    logic [OP_W-1:0]  opcode;
    logic             halted;
    logic             hold;
    ctrl_t            ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;

    assign opcode = bus.operation;
    assign hold   = halted || (opcode == OP_HALT);

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            halted <= 1'b0;
        end else if (opcode == OP_HALT) begin
            halted <= 1'b1;
        end
    end

    // A halt in flight or latched suppresses every side effect; data-path selects still decode.
    always_comb begin
        ctrl = decode(opcode);
        if (hold) begin
            ctrl.pc_wre      = 1'b0;
            ctrl.reg_wre     = 1'b0;
            ctrl.data_mem_rw = 1'b0;
            ctrl.branch      = 1'b0;
        end
    end

    cpu_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (bus.ReadData1),
        .b      (bus.B),
        .alu_op (ctrl.alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    cpu_adder32 #(.WIDTH(WIDTH)) u_pc_plus4 (
        .a   (bus.PCOut),
        .b   (WIDTH'(4)),
        .sum (pc_plus4)
    );

    cpu_adder32 #(.WIDTH(WIDTH)) u_branch_target (
        .a   (pc_plus4),
        .b   (bus.shiftResult),
        .sum (branch_target)
    );

    assign bus.ALUresult   = alu_result;
    assign bus.zero        = alu_zero;
    assign bus.Add_result1 = pc_plus4;
    assign bus.Add_result2 = branch_target;
    assign bus.PCWre       = ctrl.pc_wre;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUM2Reg    = ctrl.alu_m2reg;
    assign bus.RegWre      = ctrl.reg_wre;
    assign bus.InsMemRW    = 1'b1;
    assign bus.DataMemRW   = ctrl.data_mem_rw;
    assign bus.ExtSel      = ctrl.ext_sel;
    assign bus.PCSrc       = ctrl.branch & alu_zero;
    assign bus.RegOut      = ctrl.reg_out;
    assign bus.ALUOp       = ctrl.alu_op;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed scoreboard bench for cpu_exec_ctrl: decode, ALU, adders and halt/reset behaviour.
module tb_cpu_exec_ctrl;

    logic clk;
    logic rst;

    cpu_exec_ctrl_if #(.WIDTH(32), .OP_W(6)) bus ();

    cpu_exec_ctrl #(.WIDTH(32), .OP_W(6)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: {PCWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW, DataMemRW, ExtSel, PCSrc, RegOut}
    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] add1;
        logic [31:0] add2;
        logic [8:0]  ctl;
        logic [2:0]  aluop;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    vectors;
    int    miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] sh);
        bus.operation   = op;
        bus.ReadData1   = a;
        bus.B           = b;
        bus.PCOut       = pc;
        bus.shiftResult = sh;
    endtask

    task automatic push(input string tag, input logic [31:0] alu, input logic zero,
                        input logic [31:0] add1, input logic [31:0] add2,
                        input logic [8:0] ctl, input logic [2:0] aluop);
        exp_t e;
        e.alu   = alu;
        e.zero  = zero;
        e.add1  = add1;
        e.add2  = add2;
        e.ctl   = ctl;
        e.aluop = aluop;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare();
        exp_t        e;
        string       t;
        logic [8:0]  ctl;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        ctl = {bus.PCWre, bus.ALUSrcB, bus.ALUM2Reg, bus.RegWre, bus.InsMemRW,
               bus.DataMemRW, bus.ExtSel, bus.PCSrc, bus.RegOut};
        chk({t, ".ALUresult"},   bus.ALUresult,           e.alu);
        chk({t, ".zero"},        {31'd0, bus.zero},       {31'd0, e.zero});
        chk({t, ".Add_result1"}, bus.Add_result1,         e.add1);
        chk({t, ".Add_result2"}, bus.Add_result2,         e.add2);
        chk({t, ".ctrl"},        {23'd0, ctl},            {23'd0, e.ctl});
        chk({t, ".ALUOp"},       {29'd0, bus.ALUOp},      {29'd0, e.aluop});
    endtask

    // Drive on the falling edge, compare 1 time unit later (well away from the rising edge).
    task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] sh,
                        input logic [31:0] alu, input logic zero, input logic [31:0] add1,
                        input logic [31:0] add2, input logic [8:0] ctl, input logic [2:0] aluop);
        @(negedge clk);
        apply(op, a, b, pc, sh);
        push(tag, alu, zero, add1, add2, ctl, aluop);
        #1;
        compare();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        apply(6'b000000, 32'd0, 32'd0, 32'd0, 32'd0);
        push("reset", 32'd0, 1'b1, 32'd4, 32'd4, 9'b100110001, 3'b000);
        #1;
        compare();
        @(negedge clk);
        rst = 1'b0;

        step("add",      6'b000000, 32'd5, 32'd7, 32'h100, 32'h10,
             32'd12, 1'b0, 32'h104, 32'h114, 9'b100110001, 3'b000);
        step("beq_tk",   6'b110000, 32'h1234, 32'h1234, 32'h100, 32'h10,
             32'd0, 1'b1, 32'h104, 32'h114, 9'b100010110, 3'b001);
        step("beq_nt",   6'b110000, 32'h1234, 32'h1235, 32'h100, 32'h10,
             32'hFFFFFFFF, 1'b0, 32'h104, 32'h114, 9'b100010100, 3'b001);
        step("ori",      6'b010000, 32'hF0, 32'h0F, 32'h200, 32'h0,
             32'hFF, 1'b0, 32'h204, 32'h204, 9'b110110000, 3'b011);
        step("sub",      6'b000010, 32'd3, 32'd5, 32'h200, 32'h0,
             32'hFFFFFFFE, 1'b0, 32'h204, 32'h204, 9'b100110001, 3'b001);
        step("and",      6'b010001, 32'hF0, 32'h3C, 32'h200, 32'h0,
             32'h30, 1'b0, 32'h204, 32'h204, 9'b100110001, 3'b100);
        step("or",       6'b010010, 32'hF0, 32'h0F, 32'h200, 32'h0,
             32'hFF, 1'b0, 32'h204, 32'h204, 9'b100110001, 3'b011);
        step("addi",     6'b000001, 32'd10, 32'hFFFFFFFF, 32'h200, 32'h0,
             32'd9, 1'b0, 32'h204, 32'h204, 9'b110110100, 3'b000);
        step("move",     6'b100000, 32'h55, 32'h0, 32'h200, 32'h0,
             32'h55, 1'b0, 32'h204, 32'h204, 9'b100110001, 3'b000);
        step("lw",       6'b100111, 32'h20, 32'd4, 32'h300, 32'h8,
             32'h24, 1'b0, 32'h304, 32'h30C, 9'b111110100, 3'b000);
        step("sw",       6'b100110, 32'h20, 32'd4, 32'h300, 32'h8,
             32'h24, 1'b0, 32'h304, 32'h30C, 9'b110011100, 3'b000);
        step("undef",    6'b001111, 32'd5, 32'd7, 32'hFFFFFFFC, 32'h10,
             32'd12, 1'b0, 32'h0, 32'h10, 9'b100010000, 3'b000);

        // Halt opcode blocks side effects before the edge, then the flag holds them off.
        step("halt_pre", 6'b111111, 32'd5, 32'd7, 32'h400, 32'h0,
             32'd12, 1'b0, 32'h404, 32'h404, 9'b000010000, 3'b000);
        step("halt_add", 6'b000000, 32'd5, 32'd7, 32'h400, 32'h0,
             32'd12, 1'b0, 32'h404, 32'h404, 9'b000010001, 3'b000);
        step("halt_beq", 6'b110000, 32'h77, 32'h77, 32'h400, 32'h4,
             32'd0, 1'b1, 32'h404, 32'h408, 9'b000010100, 3'b001);

        // Reset asserted mid-cycle releases the halt without waiting for an edge.
        #2;
        rst = 1'b1;
        push("rst_mid", 32'd0, 1'b1, 32'h404, 32'h408, 9'b100010110, 3'b001);
        #1;
        compare();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 6'b110000, 32'h77, 32'h77, 32'h400, 32'h4,
             32'd0, 1'b1, 32'h404, 32'h408, 9'b100010110, 3'b001);
        step("post_add", 6'b000000, 32'd1, 32'd2, 32'h400, 32'h4,
             32'd3, 1'b0, 32'h404, 32'h408, 9'b100110001, 3'b000);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
